// File: rtl/traffic_pkg.sv
// Shared lamp encodings, fault codes and monitor state for the lamp safety monitor.
package traffic_pkg;

  typedef logic [2:0] lamp_t;

  localparam lamp_t LAMP_GREEN  = 3'b001;
  localparam lamp_t LAMP_YELLOW = 3'b010;
  localparam lamp_t LAMP_RED    = 3'b100;
  localparam lamp_t LAMP_OFF    = 3'b000;

  localparam int DEF_MIN_GREEN    = 8;
  localparam int DEF_MIN_YELLOW   = 4;
  localparam int DEF_WATCHDOG_CYC = 64;
  localparam int DEF_FLASH_HALF   = 8;
  localparam int DEF_RECOVER_CYC  = 16;

  // Lower value wins when several violations occur in the same cycle.
  typedef enum logic [2:0] {
    FC_NONE     = 3'd0,
    FC_ILLEGAL  = 3'd1,
    FC_CONFLICT = 3'd2,
    FC_SEQUENCE = 3'd3,
    FC_DWELL    = 3'd4,
    FC_WATCHDOG = 3'd5
  } fault_code_e;

  typedef enum logic [1:0] {
    MONITOR = 2'd0,
    FAULT   = 2'd1,
    RECOVER = 2'd2
  } mon_state_e;

  function automatic logic lamp_is_legal(input lamp_t lamp);
    return (lamp == LAMP_GREEN) || (lamp == LAMP_YELLOW) || (lamp == LAMP_RED);
  endfunction

endpackage

// File: rtl/lamp_safety_monitor_if.sv
// Controller-side lamp codes in, driver-side lamp codes and fault status out.
interface lamp_safety_monitor_if;
  import traffic_pkg::*;

  lamp_t       n_lights_i;
  lamp_t       s_lights_i;
  lamp_t       e_lights_i;
  lamp_t       w_lights_i;
  logic        clr_fault;

  lamp_t       n_lights;
  lamp_t       s_lights;
  lamp_t       e_lights;
  lamp_t       w_lights;
  logic        fault;
  logic [2:0]  fault_code;
  logic        in_recover;

  modport master (
    output n_lights_i, s_lights_i, e_lights_i, w_lights_i, clr_fault,
    input  n_lights, s_lights, e_lights, w_lights, fault, fault_code, in_recover
  );

  modport slave (
    input  n_lights_i, s_lights_i, e_lights_i, w_lights_i, clr_fault,
    output n_lights, s_lights, e_lights, w_lights, fault, fault_code, in_recover
  );
endinterface

// File: rtl/lamp_approach_checker.sv
// Per-approach checker: remembers the previous code and how long it has been held,
// and flags illegal codes, bad transitions and short dwell for one approach.
module lamp_approach_checker
  import traffic_pkg::*;
#(
  parameter int MIN_GREEN  = DEF_MIN_GREEN,
  parameter int MIN_YELLOW = DEF_MIN_YELLOW
) (
  input  logic  clk,
  input  logic  rst_a,
  input  logic  en_i,        // track the input (monitoring)
  input  logic  load_i,      // resync to the input with dwell saturated
  input  lamp_t lamp_i,
  output logic  illegal_o,
  output logic  sequence_o,
  output logic  dwell_o,
  output logic  non_red_o,
  output logic  changed_o
);

  localparam int DW = $clog2(((MIN_GREEN > MIN_YELLOW) ? MIN_GREEN : MIN_YELLOW) + 1);
  localparam logic [DW-1:0] DWELL_SAT = '1;
  localparam logic [DW-1:0] MIN_G     = DW'(MIN_GREEN);
  localparam logic [DW-1:0] MIN_Y     = DW'(MIN_YELLOW);

  lamp_t         prev_q, prev_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic          legal_step;

  // Violation flags for the code sampled this cycle against the remembered code.
  always_comb begin
    changed_o  = (lamp_i != prev_q);
    illegal_o  = !lamp_is_legal(lamp_i);
    non_red_o  = (lamp_i != LAMP_RED);
    legal_step = ((prev_q == LAMP_GREEN)  && (lamp_i == LAMP_YELLOW)) ||
                 ((prev_q == LAMP_YELLOW) && (lamp_i == LAMP_RED))    ||
                 ((prev_q == LAMP_RED)    && (lamp_i == LAMP_GREEN));
    sequence_o = changed_o && !legal_step;
    dwell_o    = ((prev_q == LAMP_GREEN)  && (lamp_i == LAMP_YELLOW) && (dwell_q < MIN_G)) ||
                 ((prev_q == LAMP_YELLOW) && (lamp_i == LAMP_RED)    && (dwell_q < MIN_Y));
  end

  // Next previous-code and dwell count; the dwell counter restarts at 1 on a change.
  always_comb begin
    // NOTE: defaults first so every path assigns each output and no latch is inferred.
    prev_d  = prev_q;
    dwell_d = dwell_q;
    if (load_i) begin
      prev_d  = lamp_i;
      dwell_d = DWELL_SAT;
    end else if (en_i) begin
      prev_d  = lamp_i;
      if (changed_o)                 dwell_d = DW'(1);
      else if (dwell_q != DWELL_SAT) dwell_d = dwell_q + 1'b1;
    end
  end

  // Previous-code and dwell registers; reset looks like a long-held red.
  always_ff @(posedge clk or posedge rst_a) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (rst_a) begin
      prev_q  <= LAMP_RED;
      dwell_q <= DWELL_SAT;
    end else begin
      prev_q  <= prev_d;
      dwell_q <= dwell_d;
    end
  end

endmodule

// File: rtl/lamp_safety_monitor.sv
// Lamp safety monitor: passes legal lamp codes through with one cycle of latency,
// latches the first violation and flashes red until cleared and re-qualified.
module lamp_safety_monitor
  import traffic_pkg::*;
#(
  parameter int MIN_GREEN    = DEF_MIN_GREEN,
  parameter int MIN_YELLOW   = DEF_MIN_YELLOW,
  parameter int WATCHDOG_CYC = DEF_WATCHDOG_CYC,
  parameter int FLASH_HALF   = DEF_FLASH_HALF,
  parameter int RECOVER_CYC  = DEF_RECOVER_CYC
) (
  input  logic                  clk,
  input  logic                  rst_a,
  lamp_safety_monitor_if.slave  bus
);

  localparam int WW = $clog2(WATCHDOG_CYC + 1);
  localparam int FW = $clog2(FLASH_HALF + 1);
  localparam int RW = $clog2(RECOVER_CYC + 1);
  localparam logic [WW-1:0] WD_MAX     = WW'(WATCHDOG_CYC);
  localparam logic [WW-1:0] WD_LAST    = WW'(WATCHDOG_CYC - 1);
  localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_HALF - 1);
  localparam logic [RW-1:0] REC_LAST   = RW'(RECOVER_CYC - 1);

  // Index 0..3 = north, south, east, west.
  lamp_t [3:0]   lamp_in;
  lamp_t [3:0]   lamp_q, lamp_d;
  logic  [3:0]   illegal, seq_bad, dwell_bad, non_red, changed;

  mon_state_e    state_q, state_d;
  fault_code_e   fault_code_q, fault_code_d, viol_code;
  logic [WW-1:0] wd_q;
  logic [FW-1:0] flash_cnt_q, flash_cnt_d;
  logic          phase_q, phase_d;
  logic [RW-1:0] rec_cnt_q;
  logic          conflict, bad_cycle, wd_viol, rec_done;

  assign lamp_in = {bus.w_lights_i, bus.e_lights_i, bus.s_lights_i, bus.n_lights_i};

  for (genvar g = 0; g < 4; g++) begin : g_chk
    lamp_approach_checker #(
      .MIN_GREEN  (MIN_GREEN),
      .MIN_YELLOW (MIN_YELLOW)
    ) u_chk (
      .clk        (clk),
      .rst_a      (rst_a),
      .en_i       (state_q == MONITOR),
      .load_i     (rec_done),
      .lamp_i     (lamp_in[g]),
      .illegal_o  (illegal[g]),
      .sequence_o (seq_bad[g]),
      .dwell_o    (dwell_bad[g]),
      .non_red_o  (non_red[g]),
      .changed_o  (changed[g])
    );
  end

  // Cross-approach checks and the prioritised violation for this cycle.
  always_comb begin
    conflict  = ($countones(non_red) > 1);
    bad_cycle = (|illegal) || conflict;
    wd_viol   = !(|changed) && (wd_q >= WD_LAST);
    rec_done  = (state_q == RECOVER) && !bad_cycle && (rec_cnt_q == REC_LAST);
    if (|illegal)        viol_code = FC_ILLEGAL;
    else if (conflict)   viol_code = FC_CONFLICT;
    else if (|seq_bad)   viol_code = FC_SEQUENCE;
    else if (|dwell_bad) viol_code = FC_DWELL;
    else if (wd_viol)    viol_code = FC_WATCHDOG;
    else                 viol_code = FC_NONE;
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst_a) begin
    if (rst_a) state_q <= MONITOR;
    else       state_q <= state_d;
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      MONITOR: if (viol_code != FC_NONE) state_d = FAULT;
      FAULT:   if (bus.clr_fault)        state_d = RECOVER;
      RECOVER: if (rec_done)             state_d = MONITOR;
      default:                           state_d = MONITOR;
    endcase
  end

  // Flash timer: phase starts high on the first fault cycle and toggles every FLASH_HALF cycles.
  always_comb begin
    flash_cnt_d = flash_cnt_q + 1'b1;
    phase_d     = phase_q;
    if (state_q != FAULT) begin
      flash_cnt_d = '0;
      phase_d     = 1'b1;
    end else if (flash_cnt_q == FLASH_LAST) begin
      flash_cnt_d = '0;
      phase_d     = ~phase_q;
    end
  end

  // FSM outputs: next lamp drive and latched fault code.
  always_comb begin
    lamp_d       = lamp_q;
    fault_code_d = fault_code_q;
    case (state_q)
      MONITOR: begin
        if (viol_code != FC_NONE) begin
          lamp_d       = {4{LAMP_RED}};
          fault_code_d = viol_code;
        end else begin
          lamp_d       = lamp_in;
        end
      end
      FAULT: begin
        if (bus.clr_fault) begin
          lamp_d       = {4{LAMP_RED}};
          fault_code_d = FC_NONE;
        end else begin
          lamp_d       = {4{phase_d ? LAMP_RED : LAMP_OFF}};
        end
      end
      default: lamp_d = {4{LAMP_RED}};
    endcase
  end

  // Output, fault-code and flash registers.
  always_ff @(posedge clk or posedge rst_a) begin
    if (rst_a) begin
      lamp_q       <= {4{LAMP_RED}};
      fault_code_q <= FC_NONE;
      flash_cnt_q  <= '0;
      phase_q      <= 1'b1;
    end else begin
      lamp_q       <= lamp_d;
      fault_code_q <= fault_code_d;
      flash_cnt_q  <= flash_cnt_d;
      phase_q      <= phase_d;
    end
  end

  // Watchdog: cycles the current input set has been held, counted in MONITOR only.
  always_ff @(posedge clk or posedge rst_a) begin
    if (rst_a)                  wd_q <= '0;
    else if (rec_done)          wd_q <= '0;
    else if (state_q == MONITOR) begin
      if (|changed)             wd_q <= WW'(1);
      else if (wd_q != WD_MAX)  wd_q <= wd_q + 1'b1;
    end
  end

  // Recover qualification: consecutive cycles free of illegal or conflicting codes.
  always_ff @(posedge clk or posedge rst_a) begin
    if (rst_a)                                     rec_cnt_q <= '0;
    else if (state_q != RECOVER || bad_cycle || rec_done) rec_cnt_q <= '0;
    else                                           rec_cnt_q <= rec_cnt_q + 1'b1;
  end

  assign bus.n_lights   = lamp_q[0];
  assign bus.s_lights   = lamp_q[1];
  assign bus.e_lights   = lamp_q[2];
  assign bus.w_lights   = lamp_q[3];
  assign bus.fault      = (state_q == FAULT);
  assign bus.fault_code = fault_code_q;
  assign bus.in_recover = (state_q == RECOVER);

endmodule

// File: tb/tb_lamp_safety_monitor.sv
// Directed bench for lamp_safety_monitor: nominal cycling, each fault cause,
// flashing, recovery qualification and asynchronous reset.
module tb_lamp_safety_monitor;
  import traffic_pkg::*;

  localparam logic [11:0] ALL_RED = {4{LAMP_RED}};
  localparam logic [11:0] ALL_OFF = {4{LAMP_OFF}};

  logic clk;
  logic rst_a;
  int   checks = 0;
  int   errors = 0;

  lamp_safety_monitor_if bus ();

  lamp_safety_monitor dut (
    .clk   (clk),
    .rst_a (rst_a),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Lamp vector order is {north, south, east, west}; approach 0 = north.
  function automatic logic [11:0] one_active(input int a, input lamp_t code);
    logic [11:0] v;
    v = ALL_RED;
    v[(3 - a) * 3 +: 3] = code;
    return v;
  endfunction

  function automatic logic [11:0] lamps_out();
    return {bus.n_lights, bus.s_lights, bus.e_lights, bus.w_lights};
  endfunction

  task automatic drive(input logic [11:0] v);
    bus.n_lights_i = v[11:9];
    bus.s_lights_i = v[8:6];
    bus.e_lights_i = v[5:3];
    bus.w_lights_i = v[2:0];
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_lamps(input string tag, input logic [11:0] exp);
    logic [11:0] obs;
    obs = lamps_out();
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b required %b", tag, obs, exp);
    end
  endtask

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
  endtask

  task automatic reset_dut();
    rst_a = 1'b1;
    drive(ALL_RED);
    bus.clr_fault = 1'b0;
    tick(1);
    rst_a = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1, "timeout");
  end

  initial begin
    logic [11:0] v;

    // Reset state, checked before any clock edge.
    rst_a = 1'b1;
    bus.clr_fault = 1'b0;
    drive(ALL_RED);
    #1;
    chk_lamps("reset_lamps", ALL_RED);
    chk_val("reset_fault", 32'(bus.fault), 32'd0);
    chk_val("reset_code", 32'(bus.fault_code), 32'd0);
    chk_val("reset_recover", 32'(bus.in_recover), 32'd0);
    tick(1);
    rst_a = 1'b0;

    // 1. Nominal N/S/E/W cycle, three rounds; outputs follow inputs one cycle late.
    drive(one_active(0, LAMP_GREEN));
    chk_lamps("latency_before_edge", ALL_RED);
    for (int r = 0; r < 3; r++) begin
      for (int a = 0; a < 4; a++) begin
        for (int ph = 0; ph < 2; ph++) begin
          v = one_active(a, (ph == 0) ? LAMP_GREEN : LAMP_YELLOW);
          drive(v);
          for (int c = 0; c < ((ph == 0) ? 8 : 4); c++) begin
            tick(1);
            chk_lamps("nominal_lamps", v);
            chk_val("nominal_fault", 32'(bus.fault), 32'd0);
          end
        end
      end
    end

    // 2. Conflict during north green: fault code 2, red for 8 cycles then dark.
    drive(one_active(0, LAMP_GREEN));
    tick(3);
    chk_lamps("pre_conflict", one_active(0, LAMP_GREEN));
    v = one_active(0, LAMP_GREEN);
    v[8:6] = LAMP_GREEN;
    drive(v);
    tick(1);
    chk_val("conflict_fault", 32'(bus.fault), 32'd1);
    chk_val("conflict_code", 32'(bus.fault_code), 32'd2);
    chk_lamps("conflict_flash_c1", ALL_RED);
    drive(one_active(0, LAMP_GREEN));
    for (int k = 2; k <= 8; k++) begin
      tick(1);
      chk_lamps("flash_red_half", ALL_RED);
    end
    tick(1);
    chk_lamps("flash_dark_c9", ALL_OFF);
    chk_val("flash_code_held", 32'(bus.fault_code), 32'd2);

    // 6. Clear into RECOVER; a conflict at recover cycle 10 restarts qualification.
    bus.clr_fault = 1'b1;
    tick(1);
    bus.clr_fault = 1'b0;
    chk_val("clr_recover", 32'(bus.in_recover), 32'd1);
    chk_val("clr_fault", 32'(bus.fault), 32'd0);
    chk_val("clr_code", 32'(bus.fault_code), 32'd0);
    chk_lamps("recover_lamps", ALL_RED);
    tick(9);
    v = one_active(0, LAMP_GREEN);
    v[8:6] = LAMP_GREEN;
    drive(v);
    tick(1);
    chk_val("recover_conflict_no_refault", 32'(bus.fault), 32'd0);
    chk_lamps("recover_conflict_lamps", ALL_RED);
    drive(one_active(0, LAMP_GREEN));
    tick(15);
    chk_val("recover_15_after_conflict", 32'(bus.in_recover), 32'd1);
    tick(1);
    chk_val("recover_16_after_conflict", 32'(bus.in_recover), 32'd0);
    chk_lamps("recover_exit_lamps", ALL_RED);
    tick(1);
    chk_lamps("monitor_after_recover", one_active(0, LAMP_GREEN));
    chk_val("monitor_after_recover_fault", 32'(bus.fault), 32'd0);

    // 3. Illegal code with a conflict: ILLEGAL wins and later violations do not overwrite it.
    v = one_active(0, 3'b011);
    v[8:6] = LAMP_GREEN;
    drive(v);
    tick(1);
    chk_val("illegal_code", 32'(bus.fault_code), 32'd1);
    chk_lamps("illegal_lamps", ALL_RED);
    drive(one_active(2, LAMP_YELLOW));
    tick(1);
    chk_val("illegal_code_held", 32'(bus.fault_code), 32'd1);

    // Asynchronous reset mid-FAULT clears the fault without waiting for a clock.
    rst_a = 1'b1;
    #1;
    chk_val("async_reset_fault", 32'(bus.fault), 32'd0);
    chk_val("async_reset_code", 32'(bus.fault_code), 32'd0);
    chk_lamps("async_reset_lamps", ALL_RED);
    reset_dut();

    // 4. Short green, short yellow, and green straight to red.
    drive(one_active(0, LAMP_GREEN));
    tick(5);
    drive(one_active(0, LAMP_YELLOW));
    tick(1);
    chk_val("short_green_code", 32'(bus.fault_code), 32'd4);
    reset_dut();
    drive(one_active(0, LAMP_GREEN));
    tick(8);
    drive(one_active(0, LAMP_YELLOW));
    tick(3);
    chk_val("green8_yellow_ok", 32'(bus.fault), 32'd0);
    drive(ALL_RED);
    tick(1);
    chk_val("short_yellow_code", 32'(bus.fault_code), 32'd4);
    reset_dut();
    drive(one_active(0, LAMP_GREEN));
    tick(8);
    drive(ALL_RED);
    tick(1);
    chk_val("green_to_red_code", 32'(bus.fault_code), 32'd3);
    reset_dut();

    // 5. Watchdog: 63 held cycles are fine, the 64th faults.
    drive(one_active(0, LAMP_GREEN));
    tick(63);
    chk_val("watchdog_63", 32'(bus.fault), 32'd0);
    chk_lamps("watchdog_63_lamps", one_active(0, LAMP_GREEN));
    tick(1);
    chk_val("watchdog_64", 32'(bus.fault), 32'd1);
    chk_val("watchdog_64_code", 32'(bus.fault_code), 32'd5);
    chk_lamps("watchdog_64_lamps", ALL_RED);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
